// File: rtl/wb_cam_pkg.sv
// Shared types and constants for the camera-FIFO to Wishbone DMA engine.
package wb_cam_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_CNT_W = 2;
    localparam int unsigned SEL_W      = 4;

    localparam logic [SEL_W-1:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RRST  = 3'd1,
        ST_RD_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_WB_WR = 3'd4
    } state_e;

    // Append the newest byte below the bytes already collected (big-endian word build).
    function automatic logic [WORD_W-1:0] pack_be(input logic [WORD_W-BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0]        lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Collects four FIFO bytes into one big-endian 32-bit word; word_c_o includes the byte
// currently on byte_i so the caller can latch a complete word on the fourth push.
module cam_byte_pack
    import wb_cam_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [BYTE_W-1:0]     byte_i,
    output logic [WORD_W-1:0]     word_c_o,
    output logic                  last_c_o
);

    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [BYTE_CNT_W-1:0]    cnt_q;

    assign word_c_o = pack_be(shift_q, byte_i);
    assign last_c_o = (cnt_q == BYTE_CNT_W'(3));

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (push_i) begin
            shift_q <= word_c_o[WORD_W-BYTE_W-1:0];
            cnt_q   <= cnt_q + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_cam_dma.sv
// Reads bytes from a camera FIFO, packs them into words and writes them out as
// single Wishbone write cycles to consecutive word addresses.
module wb_cam_dma
    import wb_cam_pkg::*;
#(
    parameter int unsigned WB_ADR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH    = 20,
    parameter int unsigned RRST_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WB_ADR_WIDTH-1:0] base_adr,
    input  logic [CNT_WIDTH-1:0]    word_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    fifo_rclk,
    output logic                    fifo_rrst,
    input  logic [BYTE_W-1:0]       fifo_din,
    output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
    output logic [WORD_W-1:0]       wb_dat_o,
    output logic [SEL_W-1:0]        wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int unsigned RRST_CNT_W = (RRST_CYCLES > 1) ? $clog2(RRST_CYCLES) : 1;

    state_e                  state_q;
    logic [WB_ADR_WIDTH-1:0] adr_q;
    logic [CNT_WIDTH-1:0]    rem_q;
    logic [RRST_CNT_W-1:0]   rrst_cnt_q;
    logic                    abort_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic                    rclk_q;
    logic                    rrst_q;
    logic                    cyc_q;
    logic [SEL_W-1:0]        sel_q;
    logic [WB_ADR_WIDTH-1:0] wb_adr_q;
    logic [WORD_W-1:0]       wb_dat_q;

    logic                    pack_clr_c;
    logic                    pack_push_c;
    logic                    pack_last_c;
    logic [WORD_W-1:0]       pack_word_c;

    // Packer is held empty whenever idle, which also discards partial words on abort.
    assign pack_clr_c  = (state_q == ST_IDLE);
    assign pack_push_c = (state_q == ST_RD_LO) && !abort;

    cam_byte_pack u_pack (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (pack_clr_c),
        .push_i   (pack_push_c),
        .byte_i   (fifo_din),
        .word_c_o (pack_word_c),
        .last_c_o (pack_last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            rem_q      <= '0;
            rrst_cnt_q <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rclk_q     <= 1'b0;
            rrst_q     <= 1'b0;
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        abort_q <= 1'b0;
                        adr_q   <= base_adr;
                        rem_q   <= word_cnt;
                        if (word_cnt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q     <= 1'b1;
                            rrst_q     <= 1'b1;
                            rclk_q     <= 1'b1;
                            rrst_cnt_q <= RRST_CNT_W'(RRST_CYCLES - 1);
                            state_q    <= ST_RRST;
                        end
                    end
                end

                ST_RRST: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        rrst_q  <= 1'b0;
                        rclk_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (rrst_cnt_q == '0) begin
                        rrst_q  <= 1'b0;
                        rclk_q  <= 1'b1;
                        state_q <= ST_RD_HI;
                    end else begin
                        rrst_cnt_q <= rrst_cnt_q - RRST_CNT_W'(1);
                        rclk_q     <= ~rclk_q;
                    end
                end

                ST_RD_HI: begin
                    rclk_q <= 1'b0;
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RD_LO;
                    end
                end

                ST_RD_LO: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (pack_last_c) begin
                        cyc_q    <= 1'b1;
                        sel_q    <= WB_SEL_ALL;
                        wb_adr_q <= adr_q;
                        wb_dat_q <= pack_word_c;
                        state_q  <= ST_WB_WR;
                    end else begin
                        rclk_q  <= 1'b1;
                        state_q <= ST_RD_HI;
                    end
                end

                ST_WB_WR: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    // Error termination wins over a simultaneous ack.
                    if (wb_err_i) begin
                        cyc_q   <= 1'b0;
                        sel_q   <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        sel_q <= '0;
                        adr_q <= adr_q + WB_ADR_WIDTH'(4);
                        rem_q <= rem_q - CNT_WIDTH'(1);
                        if (abort_q || abort) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (rem_q == CNT_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            rclk_q  <= 1'b1;
                            state_q <= ST_RD_HI;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    rclk_q  <= 1'b0;
                    rrst_q  <= 1'b0;
                    cyc_q   <= 1'b0;
                    sel_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign fifo_rclk = rclk_q;
    assign fifo_rrst = rrst_q;
    assign wb_adr_o  = wb_adr_q;
    assign wb_dat_o  = wb_dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = cyc_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_wb_cam_dma.sv
// Randomized bench for wb_cam_dma: FIFO and Wishbone slave models plus a word-list reference.
module tb_wb_cam_dma;

    localparam int unsigned AW  = 32;
    localparam int unsigned CW  = 20;
    localparam int unsigned RRC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_adr = '0;
    logic [CW-1:0] word_cnt = '0;
    logic          busy, done, err, fifo_rclk, fifo_rrst;
    logic [7:0]    fifo_din;
    logic [AW-1:0] wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_cam_dma #(.WB_ADR_WIDTH(AW), .CNT_WIDTH(CW), .RRST_CYCLES(RRC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_adr(base_adr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .err(err),
        .fifo_rclk(fifo_rclk), .fifo_rrst(fifo_rrst), .fifo_din(fifo_din),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Camera FIFO: pointer cleared by rrst, one byte presented per completed rclk-high phase.
    logic [7:0] mem [0:63];
    logic [5:0] ptr = '0;
    always @(posedge clk) begin
        if (fifo_rrst)      ptr <= '0;
        else if (fifo_rclk) ptr <= ptr + 6'd1;
    end
    assign fifo_din = (ptr == 6'd0) ? 8'h00 : mem[ptr - 6'd1];

    int rrst_cycles = 0;
    int cyc_rises   = 0;
    int cyc_hi      = 0;
    logic prev_cyc  = 1'b0;
    always @(posedge clk) begin
        if (fifo_rrst) rrst_cycles++;
        if (wb_cyc_o) cyc_hi++;
        if (wb_cyc_o && !prev_cyc) cyc_rises++;
        prev_cyc = wb_cyc_o;
    end

    // Wishbone slave: terminates after ack_delay wait cycles, error on word err_at.
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    int ack_delay = 0;
    int err_at    = -1;
    int wait_cnt  = 0;
    int term_idx  = 0;
    always @(negedge clk) begin
        if (wb_ack_i || wb_err_i) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wait_cnt = 0;
        end else if (!wb_cyc_o || !wb_stb_o) begin
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            if (term_idx == err_at) begin
                wb_err_i = 1'b1;
                wb_ack_i = 1'($urandom_range(0, 1));
            end else begin
                wb_ack_i = 1'b1;
            end
            if (exp_adr.size() == 0) begin
                check("unexpected_cycle", 64'(wb_cyc_o), 64'd0);
            end else begin
                check("wb_adr", 64'(wb_adr_o), 64'(exp_adr.pop_front()));
                check("wb_dat", 64'(wb_dat_o), 64'(exp_dat.pop_front()));
                check("wb_sel", 64'(wb_sel_o), 64'hF);
                check("wb_we",  64'(wb_we_o),  64'd1);
            end
            term_idx++;
        end else begin
            wait_cnt++;
        end
    end

    task automatic fill_mem(input bit fixed);
        for (int i = 0; i < 64; i++) mem[i] = fixed ? 8'(i + 1) : 8'($urandom_range(0, 255));
    endtask

    // Reference: word i goes to base+4i (mod 2^32) as bytes 4i..4i+3, most significant first.
    task automatic expect_words(input logic [31:0] base, input int nwords);
        exp_adr.delete();
        exp_dat.delete();
        for (int i = 0; i < nwords; i++) begin
            exp_adr.push_back(base + 32'(4 * i));
            exp_dat.push_back({mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]});
        end
    endtask

    task automatic pulse_start(input logic [31:0] base, input int n);
        @(negedge clk);
        base_adr = base;
        word_cnt = CW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_cyc(input string tag);
        for (int i = 0; i < 3000 && !wb_cyc_o; i++) @(negedge clk);
        check(tag, 64'(wb_cyc_o), 64'd1);
    endtask

    task automatic wait_rd_hi(input string tag);
        for (int i = 0; i < 3000 && !(fifo_rclk && !fifo_rrst); i++) @(negedge clk);
        check(tag, 64'(fifo_rclk && !fifo_rrst), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_err"},  64'(err), 0);
        check({tag, "_rclk"}, 64'(fifo_rclk), 0);
        check({tag, "_rrst"}, 64'(fifo_rrst), 0);
        check({tag, "_cyc"},  64'(wb_cyc_o), 0);
        check({tag, "_stb"},  64'(wb_stb_o), 0);
        check({tag, "_we"},   64'(wb_we_o), 0);
        check({tag, "_sel"},  64'(wb_sel_o), 0);
        check({tag, "_adr"},  64'(wb_adr_o), 0);
        check({tag, "_dat"},  64'(wb_dat_o), 0);
    endtask

    // Full transfer against the reference; err_word < 0 means no bus error.
    task automatic run_xfer(input logic [31:0] base, input int n, input int err_word,
                            input int delay, input bit fixed);
        int nterm;
        int r0, c0, h0;
        bit has_err;
        has_err = (err_word >= 0) && (err_word < n);
        nterm   = has_err ? err_word + 1 : n;
        fill_mem(fixed);
        expect_words(base, nterm);
        ack_delay = delay;
        err_at    = has_err ? err_word : -1;
        term_idx  = 0;
        r0 = rrst_cycles; c0 = cyc_rises; h0 = cyc_hi;
        pulse_start(base, n);
        check("busy_after_start", 64'(busy), 64'(n != 0));
        check("done_after_start", 64'(done), 64'(n == 0));
        wait_idle("xfer_idle");
        repeat (2) @(negedge clk);
        check("xfer_done", 64'(done), 64'(n != 0 || n == 0));
        check("xfer_err", 64'(err), 64'(has_err));
        check("writes_left", 64'(exp_adr.size()), 64'd0);
        check("rrst_cycles", 64'(rrst_cycles - r0), 64'(n == 0 ? 0 : RRC));
        check("bus_cycles", 64'(cyc_rises - c0), 64'(nterm));
        check("cyc_hi_cycles", 64'(cyc_hi - h0), 64'(nterm * (delay + 1)));
    endtask

    initial begin
        int c0, h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_xfer(32'h0000_1000, 2, -1, 1, 1'b1);
        run_xfer(32'h0000_2000, 0, -1, 1, 1'b0);
        run_xfer(32'hFFFF_FFFC, 2, -1, 0, 1'b0);
        run_xfer(32'h0000_3000, 3, 0, 1, 1'b0);

        // Abort while a bus cycle is outstanding: the cycle still waits for its ack.
        fill_mem(1'b0);
        expect_words(32'h0000_4000, 1);
        ack_delay = 3; err_at = -1; term_idx = 0;
        c0 = cyc_rises; h0 = cyc_hi;
        pulse_start(32'h0000_4000, 3);
        wait_cyc("abort_wb_cyc");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort_wb_idle");
        repeat (3) @(negedge clk);
        check("abort_wb_done", 64'(done), 0);
        check("abort_wb_err", 64'(err), 0);
        check("abort_wb_cycles", 64'(cyc_rises - c0), 1);
        check("abort_wb_cyc_hi", 64'(cyc_hi - h0), 4);
        check("abort_wb_left", 64'(exp_adr.size()), 0);

        // Abort during FIFO reads: idle next cycle, nothing written.
        expect_words(32'h0, 0);
        c0 = cyc_rises;
        pulse_start(32'h0000_5000, 2);
        wait_rd_hi("abort_rd_hi");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rd_busy", 64'(busy), 0);
        repeat (20) @(negedge clk);
        check("abort_rd_done", 64'(done), 0);
        check("abort_rd_cycles", 64'(cyc_rises - c0), 0);

        // A second start while busy is ignored.
        fill_mem(1'b0);
        expect_words(32'h0000_6000, 2);
        ack_delay = 1; err_at = -1; term_idx = 0;
        pulse_start(32'h0000_6000, 2);
        repeat (5) @(negedge clk);
        pulse_start(32'h0000_7000, 1);
        wait_idle("restart_idle");
        repeat (2) @(negedge clk);
        check("restart_done", 64'(done), 1);
        check("restart_left", 64'(exp_adr.size()), 0);

        // Reset during RD_LO.
        expect_words(32'h0, 0);
        pulse_start(32'h0000_8000, 3);
        wait_rd_hi("rst_rd_hi");
        @(negedge clk);
        check("rst_in_rd_lo", 64'(fifo_rclk), 0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_rd_lo");
        rst = 1'b0;

        // Reset in the middle of a bus cycle.
        fill_mem(1'b0);
        expect_words(32'h0000_9000, 1);
        ack_delay = 3; err_at = -1; term_idx = 0;
        pulse_start(32'h0000_9000, 2);
        wait_cyc("rst_wb_cyc");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_wb");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_xfer(32'h0000_A000, 1, -1, 0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            int n, ew, dl;
            logic [31:0] b;
            b  = $urandom;
            n  = $urandom_range(1, 4);
            ew = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            dl = $urandom_range(0, 3);
            run_xfer(b, n, ew, dl, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
